// File: rtl/hamming_minmax_engine.sv
`default_nettype none
// =============================================================================
// hamming_minmax_engine: minimum and maximum pairwise Hamming distance over
// operands read from byte memory. Define HAM_PAIR_WRITE_EN to store pair indices.
// Revision: 1.0
// =============================================================================
module hamming_minmax_engine #(
  parameter  int WORD_W      = 16,
  parameter  int MEM_W       = 8,
  parameter  int NUM_WORDS   = 32,
  parameter  int ADDR_W      = 8,
  parameter  int BASE_ADDR   = 0,
  parameter  int RESULT_ADDR = 64,
  localparam int BPW         = WORD_W / MEM_W,
  localparam int DIST_W      = $clog2(WORD_W + 1),
  localparam int IDX_W       = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [MEM_W-1:0]  mem_rd_data,
  output logic              mem_wr_en,
  output logic [MEM_W-1:0]  mem_wr_data,
  output logic [DIST_W-1:0] min_dist,
  output logic [DIST_W-1:0] max_dist,
  output logic [IDX_W-1:0]  min_idx_a,
  output logic [IDX_W-1:0]  min_idx_b,
  output logic [IDX_W-1:0]  max_idx_a,
  output logic [IDX_W-1:0]  max_idx_b
);

  localparam int NBYTES = NUM_WORDS * BPW;
  localparam int CNT_W  = $clog2(NBYTES + 2);
  localparam int BIX_W  = (BPW > 1) ? $clog2(BPW) : 1;
`ifdef HAM_PAIR_WRITE_EN
  localparam int NWR = 6;
`else
  localparam int NWR = 2;
`endif

  if (NUM_WORDS < 2) begin : g_bad_num_words
    $error("hamming_minmax_engine: NUM_WORDS must be >= 2");
  end
  if ((WORD_W % MEM_W) != 0) begin : g_bad_word_w
    $error("hamming_minmax_engine: WORD_W must be a multiple of MEM_W");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CMP, S_WRITE, S_DONE} state_t;

  state_t              state_q;
  logic                start_q;
  logic                done_q, busy_q, wr_en_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [MEM_W-1:0]    wr_data_q;
  logic [DIST_W-1:0]   min_dist_q, max_dist_q;
  logic [IDX_W-1:0]    min_a_q, min_b_q, max_a_q, max_b_q;
  logic [IDX_W-1:0]    j_q, k_q, wix_q;
  logic [BIX_W-1:0]    bix_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORD_W-1:0]   ops_q [NUM_WORDS];

  logic [DIST_W-1:0]   w_dist, min_dist_d, max_dist_d;
  logic                w_min_upd, w_max_upd;
  logic [2:0]          w_sel;
  logic [MEM_W-1:0]    w_wr_val;

  function automatic logic [DIST_W-1:0] popcnt(input logic [WORD_W-1:0] v);
    logic [DIST_W-1:0] c;
    c = '0;
    for (int i = 0; i < WORD_W; i++) c = c + DIST_W'(v[i]);
    return c;
  endfunction

  // Strict comparisons: on ties the earlier pair keeps the extreme.
  always_comb begin
    w_dist     = popcnt(ops_q[j_q] ^ ops_q[k_q]);
    w_min_upd  = (w_dist < min_dist_q);
    w_max_upd  = (w_dist > max_dist_q);
    min_dist_d = w_min_upd ? w_dist : min_dist_q;
    max_dist_d = w_max_upd ? w_dist : max_dist_q;
  end

  always_comb begin
    w_sel    = 3'(cnt_q) + 3'd1;
    w_wr_val = '0;
    case (w_sel)
      3'd1:    w_wr_val = MEM_W'(max_dist_q);
      3'd2:    w_wr_val = MEM_W'(min_a_q);
      3'd3:    w_wr_val = MEM_W'(min_b_q);
      3'd4:    w_wr_val = MEM_W'(max_a_q);
      3'd5:    w_wr_val = MEM_W'(max_b_q);
      default: w_wr_val = MEM_W'(min_dist_q);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      min_dist_q <= DIST_W'(WORD_W);
      max_dist_q <= '0;
      min_a_q    <= '0;
      min_b_q    <= '0;
      max_a_q    <= '0;
      max_b_q    <= '0;
      j_q        <= '0;
      k_q        <= '0;
      wix_q      <= '0;
      bix_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_WORDS; i++) ops_q[i] <= '0;
    end else begin
      start_q <= start;
      case (state_q)
        S_IDLE: begin
          if (start_q && !start) begin
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
            min_dist_q <= DIST_W'(WORD_W);
            max_dist_q <= '0;
            min_a_q    <= '0;
            min_b_q    <= IDX_W'(1);
            max_a_q    <= '0;
            max_b_q    <= IDX_W'(1);
            addr_q     <= ADDR_W'(BASE_ADDR);
            cnt_q      <= '0;
            wix_q      <= '0;
            bix_q      <= '0;
          end
        end
        S_LOAD: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q < CNT_W'(NBYTES - 1)) addr_q <= addr_q + ADDR_W'(1);
          // Read data trails the address by one cycle, so cycle 0 captures nothing.
          if (cnt_q != '0) begin
            ops_q[wix_q] <= (ops_q[wix_q] << MEM_W) | WORD_W'(mem_rd_data);
            if (bix_q == BIX_W'(BPW - 1)) begin
              bix_q <= '0;
              wix_q <= wix_q + IDX_W'(1);
            end else begin
              bix_q <= bix_q + BIX_W'(1);
            end
          end
          if (cnt_q == CNT_W'(NBYTES)) begin
            state_q <= S_CMP;
            j_q     <= '0;
            k_q     <= IDX_W'(1);
          end
        end
        S_CMP: begin
          min_dist_q <= min_dist_d;
          max_dist_q <= max_dist_d;
          if (w_min_upd) begin
            min_a_q <= j_q;
            min_b_q <= k_q;
          end
          if (w_max_upd) begin
            max_a_q <= j_q;
            max_b_q <= k_q;
          end
          if (k_q == IDX_W'(NUM_WORDS - 1)) begin
            if (j_q == IDX_W'(NUM_WORDS - 2)) begin
              state_q   <= S_WRITE;
              cnt_q     <= '0;
              wr_en_q   <= 1'b1;
              addr_q    <= ADDR_W'(RESULT_ADDR);
              wr_data_q <= MEM_W'(min_dist_d);
            end else begin
              j_q <= j_q + IDX_W'(1);
              k_q <= j_q + IDX_W'(2);
            end
          end else begin
            k_q <= k_q + IDX_W'(1);
          end
        end
        S_WRITE: begin
          if (cnt_q == CNT_W'(NWR - 1)) begin
            state_q <= S_DONE;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
            addr_q    <= ADDR_W'(RESULT_ADDR) + ADDR_W'(w_sel);
            wr_data_q <= w_wr_val;
          end
        end
        S_DONE: begin
          if (start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done        = done_q;
  assign busy        = busy_q;
  assign mem_addr    = addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign min_dist    = min_dist_q;
  assign max_dist    = max_dist_q;
  assign min_idx_a   = min_a_q;
  assign min_idx_b   = min_b_q;
  assign max_idx_a   = max_a_q;
  assign max_idx_b   = max_b_q;

endmodule
`default_nettype wire

// File: doc/hamming_minmax_engine.md
Name: hamming_minmax_engine

Overview:
Parametrised hardware engine for the program-1 workload: minimum and maximum pairwise Hamming distance over NUM_WORDS operands of WORD_W bits held in byte-wide data memory. It replaces the software loop and sits beside data_mem inside top, driving one shared memory port. It also reports the index pair that produced each extreme, using the same start/done handshake as the program-1 bench.

Parameters:
WORD_W, 16, operand width in bits; must be a multiple of MEM_W
MEM_W, 8, data memory word width
NUM_WORDS, 32, operand count; must be >= 2, otherwise elaboration error
ADDR_W, 8, memory address width
BASE_ADDR, 0, address of the first byte of operand 0
RESULT_ADDR, 64, min is written here and max at RESULT_ADDR+1
(derived) BPW = WORD_W/MEM_W; DIST_W = $clog2(WORD_W+1); IDX_W = $clog2(NUM_WORDS)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request; a run is launched by a 1->0 transition
done  out  1  high in DONE state
busy  out  1  high in LOAD/CMP/WRITE states
mem_addr  out  ADDR_W  memory address
mem_rd_data  in  MEM_W  read data, valid 1 cycle after mem_addr
mem_wr_en  out  1  write strobe
mem_wr_data  out  MEM_W  write data
min_dist, max_dist  out  DIST_W  result distances
min_idx_a, min_idx_b, max_idx_a, max_idx_b  out  IDX_W  pair indices (a<b)

Behaviour:
- Reset values: done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, min_dist=WORD_W, max_dist=0, all idx=0. State goes to IDLE.
- The start edge detector keeps a registered copy of start, reset to 0. The run is triggered when the registered copy is 1 and start is 0.
- IDLE -> LOAD on the trigger. min_dist/max_dist are reinitialised to WORD_W/0 in the same cycle.
- LOAD:
  - Issues NUM_WORDS*BPW sequential reads from BASE_ADDR.
  - Data lands one cycle later. Operand i = {byte[BASE+i*BPW], ..., byte[BASE+i*BPW+BPW-1]}, first byte most significant.
  - Operands are cached in an internal register array.
  - Duration is NUM_WORDS*BPW+1 cycles.
- CMP:
  - Walks pairs (j,k), j<k, in lexicographic order, one pair per cycle: N(N-1)/2 cycles.
  - dist = popcount(op[j]^op[k]).
  - Update rules are strict: dist<min updates min and its indices; dist>max updates max and its indices. The first-encountered pair therefore wins ties.
- WRITE:
  - Two cycles with mem_wr_en=1.
  - Cycle 1: RESULT_ADDR <- min_dist; cycle 2: RESULT_ADDR+1 <- max_dist.
  - Both values are zero-extended to MEM_W.
- DONE: done=1, busy=0, results held. DONE -> IDLE when start returns to 1, and done drops the next cycle.
- start toggling while busy is ignored. The edge detector keeps tracking, but a trigger is acted on only in IDLE.
- Asserting reset mid-run aborts immediately: mem_wr_en drops asynchronously, no partial write completes, and results return to reset values.
- mem_wr_en is never high outside WRITE. The memory port is idle (mem_addr holds its last value) in IDLE, CMP and DONE.
- Total latency from trigger to done for the defaults: 65 + 496 + 2 + 1 = 564 cycles.

Optional Feature:
HAM_PAIR_WRITE_EN:
- Defined: WRITE lasts 6 cycles and additionally stores min_idx_a, min_idx_b, max_idx_a, max_idx_b to RESULT_ADDR+2..+5, zero-extended.
- Undefined: WRITE is 2 cycles, and RESULT_ADDR+2 onward are never written. The index ports exist in both builds.

Test Plan:
- All 32 operands = 16'h0000 -> min=0 at (0,1), max=0 at (0,1). mem[64]=0, mem[65]=0 after 564 cycles.
- op0=16'h0000, op1=16'hFFFF, all others 16'h00FF -> max=16 at (0,1), min=0 at (2,3). mem[65]=16.
- Random operands, 10 iterations -> mem[64]/mem[65] match the reference popcount model. Indices match first-occurrence tie-breaking.
- Reset pulsed 100 cycles into CMP, then a fresh start 1->0 -> clean run with correct results, and no write to 64/65 during the aborted run.
- start held at 0 after done, then 0->1->0 -> done falls 1 cycle after start rises, and the second run reproduces identical results.
- WORD_W=32, NUM_WORDS=4, ops {32'h0, 32'hFFFFFFFF, 32'h1, 32'h3} -> max=32 at (0,1), min=1 at (0,2).
- With HAM_PAIR_WRITE_EN on the second scenario's data -> mem[66..69] = 2,3,0,1.
